// File: rtl/bus_mem_responder.sv
// bus_mem_responder: synchronous word memory behind the read/enable/addr bus.
// Accepts one request per clock. A write updates the addressed word on the
// request edge. A read returns the addressed word READ_LATENCY edges later,
// together with a one-cycle data_valid strobe. Out-of-range requests raise
// addr_err: a write raises it the cycle after the request, and a read raises
// it in the same cycle as its data_valid, with data forced to zero.
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset; flushes reads and refills memory
//   enable     request qualifier
//   read       1 = read request, 0 = write request
//   addr       word address (ADDR_WIDTH bits)
//   wdata      write data (DATA_WIDTH bits)
//   data       read data; holds its last value while data_valid = 0
//   data_valid one-cycle strobe for each completed read
//   addr_err   one-cycle strobe for an out-of-range request
module bus_mem_responder #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned READ_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_FILL = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    output logic                  addr_err
);

    // Reject illegal configurations at elaboration.
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("bus_mem_responder: READ_LATENCY must be within 1..4");
    end
    if (DEPTH < 1 || 64'(DEPTH) > (64'(1) << ADDR_WIDTH)) begin : g_bad_depth
        $error("bus_mem_responder: DEPTH must be within 1..2**ADDR_WIDTH");
    end

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_V = (ADDR_WIDTH + 1)'(DEPTH);

    // One read in flight: its returned word and whether it was out of range.
    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } stage_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             in_range_c;
    logic [IDX_W-1:0] idx_c;
    logic             wr_err_c;
    stage_t           req_c;
    stage_t           arr_c;

    // Decode the current request; an out-of-range read carries zero data.
    always_comb begin
        in_range_c = ({1'b0, addr} < DEPTH_V);
        idx_c      = IDX_W'(addr);
        wr_err_c   = enable & ~read & ~in_range_c;
        req_c.valid = enable & read;
        req_c.err   = ~in_range_c;
        req_c.data  = in_range_c ? mem[idx_c] : '0;
    end

    // Storage array; every word is refilled on reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_FILL;
            end
        end else if (enable && !read && in_range_c) begin
            mem[idx_c] <= wdata;
        end
    end

    // Delay line feeding the output register. With a latency of one, the
    // request itself arrives at the output register on its own edge.
    if (READ_LATENCY == 1) begin : g_direct
        assign arr_c = req_c;
    end else begin : g_pipe
        stage_t pipe [READ_LATENCY-1];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                for (int unsigned k = 0; k < READ_LATENCY - 1; k++) begin
                    pipe[k] <= '0;
                end
            end else begin
                pipe[0] <= req_c;
                for (int unsigned k = 1; k < READ_LATENCY - 1; k++) begin
                    pipe[k] <= pipe[k-1];
                end
            end
        end

        assign arr_c = pipe[READ_LATENCY-2];
    end

    // Output register. A read error and a write error can land on the same
    // edge; both map onto the single addr_err strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data       <= '0;
            data_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            data_valid <= arr_c.valid;
            addr_err   <= (arr_c.valid & arr_c.err) | wr_err_c;
            if (arr_c.valid) begin
                data <= arr_c.data;
            end
        end
    end

endmodule
